// File: rtl/mssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mssd_pkg
//  Purpose  : Shared constants and helpers for the multiplexed seven-segment
//             driver. It holds the hex-to-segment table, the all-segments-off
//             code and the scan-index width helper.
//  Revision : 1.0  initial release
// ============================================================================
package mssd_pkg;

  // All segments dark. The segment code is active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex digit glyphs, active-low {g,f,e,d,c,b,a}. Entry [n] is the glyph for
  // nibble n, so the list runs from F down to 0.
  localparam logic [15:0][6:0] c_hex_seg = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Width of a digit index. It is never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational nibble to seven-segment glyph lookup.
//  Ports    : nibble  in  4  hex value
//             seg     out 7  active-low segments {g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
module hex7seg
  import mssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = c_hex_seg[nibble];

endmodule
`default_nettype wire

// File: rtl/mssd_multi.sv
`default_nettype none
// ============================================================================
//  Module   : mssd_multi
//  Purpose  : Parametrised multiplexed seven-segment driver for common-anode
//             digits. It provides frame-synchronous input shadowing,
//             leading-zero blanking, per-digit enable and blink, PWM
//             brightness, lamp test, and a dark guard cycle at each digit
//             change.
//  Ports    : clk         in   1           system clock
//             reset_n     in   1           async assert, active-low reset
//             value       in   4*N_DIGITS  hex nibble per digit, digit 0 rightmost
//             dp_value    in   N_DIGITS    decimal point per digit, 1 = lit
//             digit_en    in   N_DIGITS    1 = digit may light
//             blink_mask  in   N_DIGITS    1 = digit blinks
//             blank_lz    in   1           leading-zero blanking enable
//             lamp_test   in   1           all segments/DP on for enabled digits
//             brightness  in   PWM_BITS    lit while pwm count <= brightness
//             seg         out  7           active-low segments {g..a}
//             dp          out  1           active-low decimal point
//             an          out  N_DIGITS    active-low anodes
//             scan_idx    out  IDX_W       digit currently driven
//             frame_tick  out  1           pulse when scan_idx wraps to 0
//  Revision : 1.0  initial release
// ============================================================================
module mssd_multi
  import mssd_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [4*N_DIGITS-1:0]        value,
  input  logic [N_DIGITS-1:0]          dp_value,
  input  logic [N_DIGITS-1:0]          digit_en,
  input  logic [N_DIGITS-1:0]          blink_mask,
  input  logic                         blank_lz,
  input  logic                         lamp_test,
  input  logic [PWM_BITS-1:0]          brightness,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [N_DIGITS-1:0]          an,
  output logic [idx_w(N_DIGITS)-1:0]   scan_idx,
  output logic                         frame_tick
);

  localparam int IDX_W   = idx_w(N_DIGITS);
  localparam int SLOT_W  = $clog2(SLOT_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_CYCLES);

  // Internal scan state. The pins run one cycle behind it.
  logic [SLOT_W-1:0]     r_slot_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_frame_start;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;

  // Frame shadows of the display inputs.
  logic [4*N_DIGITS-1:0] r_sh_value;
  logic [N_DIGITS-1:0]   r_sh_dp;
  logic [N_DIGITS-1:0]   r_sh_en;
  logic [N_DIGITS-1:0]   r_sh_blink;
  logic                  r_sh_blank_lz;

  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_zero_from;
  logic                  w_lz_blank;
  logic                  w_blink_dark;
  logic                  w_pwm_on;
  logic                  w_guard;
  logic                  w_lit;
  logic [N_DIGITS-1:0]   w_an;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
  assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_W'(N_DIGITS - 1));

  // Counters: slot and digit index, PWM phase, and blink half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_pwm_cnt     <= r_pwm_cnt + PWM_BITS'(1);
      r_frame_start <= w_frame_wrap;
      if (w_slot_wrap) begin
        r_slot_cnt <= '0;
        r_idx      <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
      end
      if (r_blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Capture on the edge that moves the index back to digit 0. The whole
  // frame that follows then shows one consistent snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_value    <= '0;
      r_sh_dp       <= '0;
      r_sh_en       <= '0;
      r_sh_blink    <= '0;
      r_sh_blank_lz <= 1'b0;
    end else if (w_frame_wrap) begin
      r_sh_value    <= value;
      r_sh_dp       <= dp_value;
      r_sh_en       <= digit_en;
      r_sh_blink    <= blink_mask;
      r_sh_blank_lz <= blank_lz;
    end
  end

  assign w_nibble = r_sh_value[{r_idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (w_nibble),
    .seg    (w_seg)
  );

  // w_zero_from[i] is set when digits i..top all have a zero nibble and an
  // unlit decimal point.
  always_comb begin
    logic run;
    run         = 1'b1;
    w_zero_from = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run            = run && (r_sh_value[4*i +: 4] == 4'h0) && !r_sh_dp[i];
      w_zero_from[i] = run;
    end
  end

  assign w_lz_blank   = r_sh_blank_lz && (r_idx != '0) && w_zero_from[r_idx];
  assign w_blink_dark = r_blink_phase && r_sh_blink[r_idx];
  assign w_pwm_on     = (r_pwm_cnt <= brightness);
  assign w_guard      = (r_slot_cnt == '0);

  // Lamp test overrides only the cosmetic blanking (LZ, blink). Guard,
  // enable and PWM still gate the anode.
  assign w_lit = !w_guard && r_sh_en[r_idx] && w_pwm_on &&
                 (lamp_test || (!w_lz_blank && !w_blink_dark));

  always_comb begin
    w_an = '1;
    if (w_lit) begin
      w_an[r_idx] = 1'b0;
    end
  end

  // Registered pin stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      scan_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an;
      seg        <= lamp_test ? 7'h00 : w_seg;
      dp         <= lamp_test ? 1'b0 : ~r_sh_dp[r_idx];
      scan_idx   <= r_idx;
      frame_tick <= r_frame_start;
    end
  end

endmodule
`default_nettype wire
